// File: rtl/sfifo_pkg.sv
// Shared types and constants for sfifo and its read-side stream adapter.
package sfifo_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef logic [DEFAULT_WIDTH-1:0] data_t;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/sfifo_rd_buf2.sv
// Two-entry register buffer holding words returned by sfifo until the consumer takes them.
module sfifo_rd_buf2
  import sfifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             head;
  logic             tail;
  logic [OCC_W-1:0] occ_q;

  // NOTE: the storage is reset along with the pointers so the head word reads as zero
  // out of reset; with only two entries this costs nothing worth avoiding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      occ_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[head];
  assign occ       = occ_q;

endmodule

// File: rtl/sfifo_rd_stream.sv
// Converts sfifo's 1-cycle-latency read port into a show-ahead valid/ready stream.
// Optional delivered-beat counter m_cnt enabled by defining SFIFO_RD_STREAM_CNT_EN.
module sfifo_rd_stream
  import sfifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef SFIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]      m_cnt
`endif
);

  logic             pend;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   level;

  sfifo_rd_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (rdata),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != '0);

  // Credit check counts the in-flight word, so buffer plus pending never exceeds two.
  assign level = {1'b0, occ} + (OCC_W + 1)'(pend) - (OCC_W + 1)'(pop);
  assign rinc  = !rempty && (level < (OCC_W + 1)'(BUF_DEPTH));

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= rinc;
  end

`ifdef SFIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   m_cnt <= '0;
    else if (pop) m_cnt <= m_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Self-checking bench: behavioural sfifo model, scoreboard queue and protocol monitor.
module tb_sfifo_rd_stream;
  import sfifo_pkg::*;

  localparam int SF_DEPTH = 16;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  rempty;
  data_t rdata;
  logic  rinc;
  logic  m_valid;
  logic  m_ready;
  data_t m_data;
`ifdef SFIFO_RD_STREAM_CNT_EN
  logic [31:0] m_cnt;
`endif

  always #5 clk = ~clk;

  sfifo_rd_stream #(.WIDTH(DEFAULT_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef SFIFO_RD_STREAM_CNT_EN
    ,
    .m_cnt   (m_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural sfifo: registered read data, registered flags.
  data_t sf_q[$];
  logic  wr_en;
  data_t wr_data;
  logic  wfull;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf_q.delete();
      rempty <= 1'b1;
      wfull  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (rinc && sf_q.size() != 0) rdata <= sf_q.pop_front();
      if (wr_en && sf_q.size() < SF_DEPTH) sf_q.push_back(wr_data);
      rempty <= (sf_q.size() == 0);
      wfull  <= (sf_q.size() >= SF_DEPTH);
    end
  end

  // Scoreboard and monitor state.
  data_t exp_q[$];
  int    cyc = 0;
  int    issued = 0;
  int    delivered = 0;
  int    rinc_cnt = 0;
  int    rinc_cyc = 0;
  int    beat_cnt = 0;
  int    first_beat_cyc = 0;
  int    last_beat_cyc = 0;
  logic  prev_stall = 1'b0;
  data_t prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      check("inflight_le2", 32'((issued - delivered) <= 2), 32'd1);
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (rinc) begin
        issued++;
        rinc_cnt++;
        rinc_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        if (beat_cnt == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_cnt++;
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input data_t d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && beat_cnt < n; c++) tick();
    check(tag, 32'(beat_cnt), 32'(n));
  endtask

  task automatic clear_model();
    exp_q.delete();
    issued    = 0;
    delivered = 0;
    rinc_cnt  = 0;
    beat_cnt  = 0;
  endtask

  int    exp_cnt = 0;
  data_t first_word;

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (10) tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("rst_cnt", m_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) tick();

    // Streaming, consumer always ready.
    m_ready  = 1'b1;
    beat_cnt = 0;
    for (int i = 0; i < 20; i++) write_word(data_t'($urandom));
    wait_beats("stream_beats", 20, 200);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    check("stream_b2b", 32'(last_beat_cyc - first_beat_cyc), 32'd19);
    exp_cnt += 20;
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("stream_cnt", m_cnt, 32'(exp_cnt));
`endif

    // Backpressure: 16 words left in sfifo plus 2 held by the adapter.
    m_ready  = 1'b0;
    rinc_cnt = 0;
    beat_cnt = 0;
    for (int i = 0; i < 18; i++) write_word(data_t'($urandom));
    first_word = exp_q[0];
    repeat (30) tick();
    check("bp_rinc_pulses", 32'(rinc_cnt), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_first_word", 32'(m_data), 32'(first_word));
    m_ready = 1'b1;
    wait_beats("bp_beats", 18, 200);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_cnt += 18;
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("bp_cnt", m_cnt, 32'(exp_cnt));
`endif

    // Toggling ready with writes as fast as sfifo accepts them.
    beat_cnt = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          for (int w = 0; w < 100 && wfull; w++) tick();
          write_word(data_t'($urandom));
        end
      end
      begin
        for (int c = 0; c < 2000 && beat_cnt < 100; c++) begin
          m_ready = ~m_ready;
          tick();
        end
      end
    join
    m_ready = 1'b1;
    wait_beats("tog_beats", 100, 50);
    check("tog_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_cnt += 100;
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("tog_cnt", m_cnt, 32'(exp_cnt));
`endif

    // Last word: single entry, latency and idle afterwards.
    repeat (5) tick();
    rinc_cnt = 0;
    beat_cnt = 0;
    write_word(data_t'($urandom));
    repeat (10) tick();
    check("last_rinc_pulses", 32'(rinc_cnt), 32'd1);
    check("last_beats", 32'(beat_cnt), 32'd1);
    check("last_latency", 32'(first_beat_cyc - rinc_cyc), 32'd2);
    check("last_idle_valid", 32'(m_valid), 32'd0);
    check("last_idle_rinc", 32'(rinc), 32'd0);
    exp_cnt += 1;
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("last_cnt", m_cnt, 32'(exp_cnt));
`endif

    // Reset mid-stream with words buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(data_t'($urandom));
    repeat (6) tick();
    check("mid_valid_pre", 32'(m_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_rinc", 32'(rinc), 32'd0);
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("mid_rst_cnt", m_cnt, 32'd0);
`endif
    clear_model();
    repeat (10) tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    write_word(data_t'($urandom));
    wait_beats("post_rst_beats", 1, 20);
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef SFIFO_RD_STREAM_CNT_EN
    check("post_rst_cnt", m_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
